mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle MIPS-subset CPU.
- Decodes the instruction opcode into a per-state sequence of datapath strobes and mux selects.
- Generates the PC enable: an unconditional PC write, or branch AND ALU-zero.
- Stalls on memory accesses until the memory handshake `mem_ready` is asserted.

Parameters:
- USE_MEM_READY, default 1: 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pcen  out  1  PC register load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  register write address: 0 = rt, 1 = rd
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0 = PC, 1 = A
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct decode
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on an unknown opcode in DECODE
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - rst=1 at a clock edge -> state = FETCH.
  - While rst is high, all strobes (pcen, memwrite, irwrite, regwrite, illegal_op) are forced to 0.
  - While rst is high, all selects are 0.
  - Reset mid-instruction abandons it; the next cycle after rst falls is FETCH.
- Output style:
  - Moore outputs decoded from state; no registered outputs.
  - pcen = pcwrite | (branch & zero), combinational; pcwrite and branch are internal.
  - Signals not listed for a state are 0.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- FETCH(0):
  - Outputs: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite = mem_ready.
  - mem_ready=0 -> stay in FETCH; mem_ready=1 -> DECODE.
- DECODE(1):
  - Outputs: alusrca=0, alusrcb=11, aluop=00 (branch target precompute).
  - Next state: LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BEQ; ADDI -> ADDIEX; J -> JUMP.
  - Any other opcode -> illegal_op=1 for this cycle, next state FETCH.
- MEMADR(2):
  - Outputs: alusrca=1, alusrcb=10.
  - Next state: LW -> MEMRD; SW -> MEMWR.
- MEMRD(3):
  - Outputs: iord=1.
  - Wait here for mem_ready, then -> MEMWB.
- MEMWB(4):
  - Outputs: regdst=0, memtoreg=1, regwrite=1.
  - Next state: FETCH.
- MEMWR(5):
  - Outputs: iord=1, memwrite=1, held for every wait cycle.
  - Exit on mem_ready -> FETCH.
- EXEC(6):
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next state: ALUWB.
- ALUWB(7):
  - Outputs: regdst=1, regwrite=1.
  - Next state: FETCH.
- BEQ(8):
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1.
  - Next state: FETCH.
- ADDIEX(9):
  - Outputs: alusrca=1, alusrcb=10.
  - Next state: ADDIWB.
- ADDIWB(10):
  - Outputs: regdst=0, regwrite=1.
  - Next state: FETCH.
- JUMP(11):
  - Outputs: pcsrc=10, pcwrite=1.
  - Next state: FETCH.
- Unused encodings 12-15 -> FETCH, no strobes.
- Latency with mem_ready held at 1 (cycles per instruction): LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- Each wait cycle adds one cycle.
- opcode must stay stable from DECODE to instruction end; it is sampled every cycle and is not latched internally.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams;
  - 4-bit state encodings;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUSRCB_* and PCSRC_* constants.
- Sub-module pc_en_gen (pcwrite, branch, zero -> pcen): a 2-input AND followed by an OR.
- The rest is one always block for the state register and one for next-state/output decode.

Test Plan:
- rst high 3 cycles, then low, mem_ready=1:
  - During reset: state=0 and all strobes 0.
  - First post-reset cycle: irwrite=1, pcen=1.
- LW (100011), mem_ready=1:
  - State sequence 0,1,2,3,4,0.
  - regwrite=1 with memtoreg=1 only in state 4.
  - 5 cycles total.
- SW with mem_ready=0 for 3 cycles in MEMWR:
  - memwrite=1 for 4 consecutive cycles.
  - Returns to FETCH on the cycle after mem_ready=1.
  - Count regwrite=0 throughout.
- BEQ:
  - zero=1 -> pcen=1 in state 8, pcsrc=01.
  - zero=0 -> pcen=0.
  - Either way the next state is 0.
- Opcode 111111 in DECODE:
  - illegal_op pulses 1 cycle, next state 0, no regwrite/memwrite.
- Assert rst during MEMWR wait -> memwrite drops the same cycle rst is high; state=0 after the edge.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU main controller: opcodes, state codes
// and datapath select values.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, illegal_op, state
  );
endinterface

// File: rtl/mc_ctrl_fsm_pc_en_gen.sv
// PC load enable: unconditional write, or a taken branch.
module pc_en_gen (
  input  logic pcwrite_i,
  input  logic branch_i,
  input  logic zero_i,
  output logic pcen_o
);
  assign pcen_o = pcwrite_i | (branch_i & zero_i);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: Moore strobes/selects per
// state, with memory states stalling until the memory handshake completes.
module mc_ctrl_fsm #(
  parameter int USE_MEM_READY = 1
) (
  input logic          clk,
  input logic          rst,
  mc_ctrl_fsm_if.master bus
);
  import mc_ctrl_pkg::*;

  state_e state_q, state_d;
  logic   ready;
  logic   pcwrite;
  logic   branch;

  assign ready     = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;
  assign bus.state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; everything stays at its idle default during reset
  always_comb begin
    state_d        = S_FETCH;
    pcwrite        = 1'b0;
    branch         = 1'b0;
    bus.iord       = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = ALUSRCB_REG;
    bus.aluop      = ALUOP_ADD;
    bus.pcsrc      = PCSRC_ALU;
    bus.illegal_op = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          bus.alusrcb = ALUSRCB_FOUR;
          bus.irwrite = ready;
          pcwrite     = ready;
          if (ready) begin
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          // Branch target is precomputed here while the opcode is decoded
          bus.alusrcb = ALUSRCB_IMMSH;
          case (bus.opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BEQ;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
              bus.illegal_op = 1'b1;
              state_d        = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUSRCB_IMM;
          case (bus.opcode)
            OP_LW:   state_d = S_MEMRD;
            OP_SW:   state_d = S_MEMWR;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEMRD: begin
          bus.iord = 1'b1;
          if (ready) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_MEMRD;
          end
        end
        S_MEMWB: begin
          bus.memtoreg = 1'b1;
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
        S_MEMWR: begin
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
          if (ready) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_MEMWR;
          end
        end
        S_EXEC: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUSRCB_REG;
          bus.aluop   = ALUOP_FUNCT;
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          bus.regdst   = 1'b1;
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
        S_BEQ: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUSRCB_REG;
          bus.aluop   = ALUOP_SUB;
          bus.pcsrc   = PCSRC_ALUOUT;
          branch      = 1'b1;
          state_d     = S_FETCH;
        end
        S_ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = ALUSRCB_IMM;
          state_d     = S_ADDIWB;
        end
        S_ADDIWB: begin
          bus.regwrite = 1'b1;
          state_d      = S_FETCH;
        end
        S_JUMP: begin
          bus.pcsrc = PCSRC_JUMP;
          pcwrite   = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  pc_en_gen u_pc_en_gen (
    .pcwrite_i (pcwrite),
    .branch_i  (branch),
    .zero_i    (bus.zero),
    .pcen_o    (bus.pcen)
  );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomised bench for mc_ctrl_fsm: an instruction-sequence model predicts state
// and outputs every cycle, with directed checks pinning the model to known values.
module tb_mc_ctrl_fsm;
  typedef int seq_t[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic clk = 1'b0;
  logic rst;
  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm #(.USE_MEM_READY(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int m_state = 0;
  int s_state, s_pcen, s_irwrite, s_memwrite, s_regwrite, s_memtoreg, s_illegal, s_pcsrc;

  function automatic bit is_legal(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
  endfunction

  // Visited states for one instruction, in order, starting at FETCH.
  function automatic seq_t seq_of(input logic [5:0] op);
    seq_t q;
    if (op == LW)        q = '{0, 1, 2, 3, 4};
    else if (op == SW)   q = '{0, 1, 2, 5};
    else if (op == RT)   q = '{0, 1, 6, 7};
    else if (op == ADDI) q = '{0, 1, 9, 10};
    else if (op == BEQ)  q = '{0, 1, 8};
    else if (op == JMP)  q = '{0, 1, 11};
    else                 q = '{0, 1};
    return q;
  endfunction

  function automatic int next_state(input int st, input bit mr, input logic [5:0] op);
    seq_t q;
    if ((st == 0 || st == 3 || st == 5) && !mr) return st;
    q = seq_of(op);
    for (int i = 0; i < q.size() - 1; i++)
      if (q[i] == st) return q[i + 1];
    return 0;
  endfunction

  function automatic logic [18:0] exp_vec(input int st, input bit r, input bit mr, input bit z,
                                          input logic [5:0] op);
    logic pcen = 1'b0, iord = 1'b0, mw = 1'b0, irw = 1'b0, rdst = 1'b0, m2r = 1'b0;
    logic rw = 1'b0, asa = 1'b0, ill = 1'b0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    logic [3:0] st4;
    st4 = st[3:0];
    if (!r) begin
      case (st)
        0:  begin asb = 2'b01; irw = mr; pcen = mr; end
        1:  begin asb = 2'b11; ill = !is_legal(op); end
        2:  begin asa = 1'b1; asb = 2'b10; end
        3:  iord = 1'b1;
        4:  begin m2r = 1'b1; rw = 1'b1; end
        5:  begin iord = 1'b1; mw = 1'b1; end
        6:  begin asa = 1'b1; aop = 2'b10; end
        7:  begin rdst = 1'b1; rw = 1'b1; end
        8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcen = z; end
        9:  begin asa = 1'b1; asb = 2'b10; end
        10: rw = 1'b1;
        11: begin psrc = 2'b10; pcen = 1'b1; end
        default: ;
      endcase
    end
    return {pcen, iord, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc, ill, st4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare every output against the model, advance the model.
  task automatic cyc(input bit r, input logic [5:0] op, input bit z, input bit mr);
    logic [18:0] act;
    @(negedge clk);
    rst = r; bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
    #2;
    act = {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
           bus.regwrite, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.illegal_op, bus.state};
    chk("cycle_model", {13'd0, act}, {13'd0, exp_vec(m_state, r, mr, z, op)});
    s_state = bus.state; s_pcen = bus.pcen; s_irwrite = bus.irwrite;
    s_memwrite = bus.memwrite; s_regwrite = bus.regwrite; s_memtoreg = bus.memtoreg;
    s_illegal = bus.illegal_op; s_pcsrc = bus.pcsrc;
    @(posedge clk);
    m_state = r ? 0 : next_state(m_state, mr, op);
  endtask

  initial begin
    logic [19:0] hist;
    int mw_cnt, rw_cnt, rw_st;
    logic [5:0] cur_op;
    logic [5:0] ops [6];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    rst = 1'b1; bus.opcode = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, LW, 1'b1, 1'b1);
      chk("reset_state", s_state, 32'd0);
      chk("reset_strobes", {s_pcen[0], s_irwrite[0], s_memwrite[0], s_regwrite[0], s_illegal[0]}, 32'd0);
    end

    // LW with memory always ready
    hist = 20'd0; rw_cnt = 0; rw_st = -1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, LW, 1'b0, 1'b1);
      if (i == 0) begin
        chk("post_reset_irwrite", s_irwrite, 32'd1);
        chk("post_reset_pcen", s_pcen, 32'd1);
      end
      hist = {hist[15:0], s_state[3:0]};
      if (s_regwrite == 1) begin rw_cnt++; rw_st = s_state; chk("lw_memtoreg", s_memtoreg, 32'd1); end
    end
    chk("lw_state_seq", {12'd0, hist}, {12'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
    chk("lw_regwrite_count", rw_cnt, 32'd1);
    chk("lw_regwrite_state", rw_st, 32'd4);

    // SW stalling three cycles in MEMWR
    mw_cnt = 0; rw_cnt = 0;
    cyc(1'b0, SW, 1'b0, 1'b1);
    chk("lw_returns_fetch", s_state, 32'd0);
    cyc(1'b0, SW, 1'b0, 1'b1);
    cyc(1'b0, SW, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, SW, 1'b0, (i == 3));
      mw_cnt += s_memwrite; rw_cnt += s_regwrite;
    end
    chk("sw_memwrite_cycles", mw_cnt, 32'd4);
    chk("sw_no_regwrite", rw_cnt, 32'd0);

    // BEQ taken then not taken
    for (int t = 1; t >= 0; t--) begin
      cyc(1'b0, BEQ, 1'b0, 1'b1);
      chk("beq_prev_fetch", s_state, 32'd0);
      cyc(1'b0, BEQ, 1'b0, 1'b1);
      cyc(1'b0, BEQ, t[0], 1'b1);
      chk("beq_state", s_state, 32'd8);
      chk("beq_pcen", s_pcen, t);
      chk("beq_pcsrc", s_pcsrc, 32'd1);
    end

    // Unknown opcode
    cyc(1'b0, 6'b111111, 1'b0, 1'b1);
    chk("beq_returns_fetch", s_state, 32'd0);
    cyc(1'b0, 6'b111111, 1'b0, 1'b1);
    chk("illegal_pulse", s_illegal, 32'd1);
    chk("illegal_no_writes", {s_regwrite[0], s_memwrite[0]}, 32'd0);
    cyc(1'b0, 6'b111111, 1'b0, 1'b1);
    chk("illegal_next_fetch", s_state, 32'd0);
    chk("illegal_one_cycle", s_illegal, 32'd0);

    // Reset during a MEMWR wait
    cyc(1'b0, SW, 1'b0, 1'b1);
    cyc(1'b0, SW, 1'b0, 1'b1);
    cyc(1'b0, SW, 1'b0, 1'b0);
    chk("memwr_wait_memwrite", s_memwrite, 32'd1);
    cyc(1'b1, SW, 1'b0, 1'b0);
    chk("rst_drops_memwrite", s_memwrite, 32'd0);
    cyc(1'b0, SW, 1'b0, 1'b0);
    chk("rst_state_fetch", s_state, 32'd0);

    // Randomised traffic; opcode only changes while fetching
    cur_op = SW;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
        else cur_op = ops[$urandom_range(0, 5)];
      end
      cyc(($urandom_range(0, 39) == 0), cur_op, 1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
